// File: rtl/dsine_pkg.sv
// Shared types and constants for the Digital Sine step sequencer.
package dsine_pkg;

  localparam int DSINE_W   = 7;
  localparam int PHASE_MSB = 6;

  typedef enum logic [1:0] {
    IDLE,
    PHASE,
    OFFSET,
    HOLD
  } dsine_seq_state_t;

endpackage

// File: rtl/dsine_step_sequencer_fold.sv
// Phase fold mux: reflects the upper half of the phase so that the output is a triangle.
// Instantiated by dsine_step_sequencer only when DSINE_FOLD_EN is defined.
module dsine_phase_fold
  import dsine_pkg::*;
(
  input  logic [DSINE_W-1:0] i_phase,
  output logic [DSINE_W-1:0] o_folded
);

  always_comb begin
    o_folded = i_phase[PHASE_MSB] ? ~i_phase : i_phase;
  end

endmodule

// File: rtl/dsine_step_sequencer.sv
// Time-shares the external 7-bit adder between phase accumulation and output coding.
// Optional macro DSINE_FOLD_EN folds the phase in the OFFSET step (triangle output).
module dsine_step_sequencer
  import dsine_pkg::*;
#(
  parameter int              W          = DSINE_W,
  parameter logic [W-1:0]    PHASE_INIT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         cfg_load,
  input  logic [W-1:0] step_in,
  input  logic [W-1:0] offset_in,
  input  logic         sample_req,
  output logic         busy,
  output logic         overrun,
  output logic [W-1:0] phase,
  output logic [W-1:0] out_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W-1:0] add_s
);

  dsine_seq_state_t r_state;
  dsine_seq_state_t w_next;

  logic [W-1:0] r_phase;
  logic [W-1:0] r_step_sh;
  logic [W-1:0] r_off_sh;
  logic [W-1:0] r_step_work;
  logic [W-1:0] r_off_work;
  logic [W-1:0] r_out_code;
  logic         r_out_valid;
  logic         r_overrun;

  logic         w_accept;
  logic         w_overrun_evt;
  logic [W-1:0] w_code_a;
  logic [W-1:0] w_add_a;
  logic [W-1:0] w_add_b;

`ifdef DSINE_FOLD_EN
  dsine_phase_fold u_fold (
    .i_phase  (r_phase),
    .o_folded (w_code_a)
  );
`else
  assign w_code_a = r_phase;
`endif

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_add_a  = '0;
    w_add_b  = '0;
    case (r_state)
      IDLE: begin
        if (enable && sample_req) begin
          w_next   = PHASE;
          w_accept = 1'b1;
        end
      end
      PHASE: begin
        w_add_a = r_phase;
        w_add_b = r_step_work;
        w_next  = OFFSET;
      end
      OFFSET: begin
        w_add_a = w_code_a;
        w_add_b = r_off_work;
        w_next  = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          if (enable && sample_req) begin
            w_next   = PHASE;
            w_accept = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
    // enable low overrides every transition, including a back-to-back accept
    if (!enable) begin
      w_next   = IDLE;
      w_accept = 1'b0;
    end
  end

  // Any request that does not start a new sample is an overrun.
  assign w_overrun_evt = sample_req && !w_accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_phase     <= PHASE_INIT;
      r_step_sh   <= '0;
      r_off_sh    <= '0;
      r_step_work <= '0;
      r_off_work  <= '0;
      r_out_code  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state <= w_next;

      if (cfg_load) begin
        r_step_sh <= step_in;
        r_off_sh  <= offset_in;
        r_overrun <= 1'b0;
      end else if (w_overrun_evt) begin
        r_overrun <= 1'b1;
      end

      if (w_accept) begin
        r_step_work <= r_step_sh;
        r_off_work  <= r_off_sh;
      end

      if (!enable) begin
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          PHASE:  r_phase <= add_s;
          OFFSET: begin
            r_out_code  <= add_s;
            r_out_valid <= 1'b1;
          end
          HOLD:   if (out_ready) r_out_valid <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign overrun   = r_overrun;
  assign phase     = r_phase;
  assign out_code  = r_out_code;
  assign out_valid = r_out_valid;
  assign add_a     = w_add_a;
  assign add_b     = w_add_b;

endmodule

// File: tb/tb_dsine_step_sequencer.sv
// Self-checking bench for dsine_step_sequencer with a behavioural adder and sample model.
module tb_dsine_step_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, enable, cfg_load, sample_req, out_ready;
  logic [6:0] step_in, offset_in;
  logic       busy, overrun, out_valid;
  logic [6:0] phase, out_code, add_a, add_b, add_s;

  int n_total = 0;
  int n_pass  = 0;

  logic [6:0] m_phase, m_step, m_off;

  always #5 clk = ~clk;

  assign add_s = 7'(add_a + add_b);

  dsine_step_sequencer #(.W(7), .PHASE_INIT(7'd0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cfg_load   (cfg_load),
    .step_in    (step_in),
    .offset_in  (offset_in),
    .sample_req (sample_req),
    .busy       (busy),
    .overrun    (overrun),
    .phase      (phase),
    .out_code   (out_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_s      (add_s)
  );

  function automatic logic [6:0] next_phase(input logic [6:0] ph, input logic [6:0] st);
    return 7'((int'(ph) + int'(st)) % 128);
  endfunction

  function automatic logic [6:0] exp_code(input logic [6:0] ph, input logic [6:0] off);
    int a;
    a = int'(ph);
`ifdef DSINE_FOLD_EN
    if (a >= 64) a = 127 - a;
`endif
    return 7'((a + int'(off)) % 128);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; enable = 1'b0; cfg_load = 1'b0; sample_req = 1'b0;
    out_ready = 1'b1; step_in = '0; offset_in = '0;
    tick; tick;
    rst_n = 1'b1; enable = 1'b1;
    m_phase = '0; m_step = '0; m_off = '0;
  endtask

  task automatic cfg(input logic [6:0] s, input logic [6:0] o);
    cfg_load = 1'b1; step_in = s; offset_in = o;
    tick;
    cfg_load = 1'b0;
    m_step = s; m_off = o;
  endtask

  task automatic test_reset;
    do_reset;
    n_total++; if (phase !== 7'd0) $display("FAIL reset_phase: got %0d want 0", phase); else n_pass++;
    n_total++; if (out_code !== 7'd0) $display("FAIL reset_code: got %0d want 0", out_code); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %0b want 0", overrun); else n_pass++;
    n_total++; if (add_a !== 7'd0 || add_b !== 7'd0)
      $display("FAIL reset_add: got a=%0d b=%0d want 0/0", add_a, add_b); else n_pass++;
  endtask

  task automatic test_single;
    do_reset;
    cfg(7'd5, 7'd10);
    sample_req = 1'b1; tick; sample_req = 1'b0;
    n_total++; if (busy !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL single_phase_flags: got busy=%0b valid=%0b want 1/0", busy, out_valid); else n_pass++;
    n_total++; if (add_a !== 7'd0 || add_b !== 7'd5)
      $display("FAIL single_phase_ops: got a=%0d b=%0d want 0/5", add_a, add_b); else n_pass++;
    tick;
    n_total++; if (add_a !== 7'd5 || add_b !== 7'd10)
      $display("FAIL single_offset_ops: got a=%0d b=%0d want 5/10", add_a, add_b); else n_pass++;
    n_total++; if (phase !== 7'd5 || out_valid !== 1'b0)
      $display("FAIL single_offset_state: got phase=%0d valid=%0b want 5/0", phase, out_valid); else n_pass++;
    tick;
    n_total++; if (out_valid !== 1'b1 || out_code !== 7'd15)
      $display("FAIL single_result: got valid=%0b code=%0d want 1/15", out_valid, out_code); else n_pass++;
    tick;
    n_total++; if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL single_release: got valid=%0b busy=%0b want 0/0", out_valid, busy); else n_pass++;
  endtask

  task automatic test_wrap;
    bit to;
    logic [6:0] exp;
    do_reset;
    cfg(7'd100, 7'd0);
    for (int k = 0; k < 2; k++) begin
      sample_req = 1'b1; tick; sample_req = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 6; i++) begin
        tick;
        if (out_valid) begin to = 1'b0; break; end
      end
      m_phase = next_phase(m_phase, m_step);
      exp = exp_code(m_phase, m_off);
      n_total++; if (to) $display("FAIL wrap_timeout: got no out_valid want out_valid");
      else if (out_code !== exp) $display("FAIL wrap_code: got %0d want %0d", out_code, exp); else n_pass++;
      tick;
    end
    n_total++; if (phase !== 7'd72) $display("FAIL wrap_phase: got %0d want 72", phase); else n_pass++;
  endtask

  task automatic test_fold;
    bit to;
    logic [6:0] exp;
`ifdef DSINE_FOLD_EN
    exp = 7'd30;
`else
    exp = 7'd103;
`endif
    do_reset;
    cfg(7'd100, 7'd3);
    sample_req = 1'b1; tick; sample_req = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (out_valid) begin to = 1'b0; break; end
    end
    n_total++; if (to) $display("FAIL fold_timeout: got no out_valid want out_valid");
    else if (out_code !== exp) $display("FAIL fold_code: got %0d want %0d", out_code, exp); else n_pass++;
    n_total++; if (phase !== 7'd100) $display("FAIL fold_phase: got %0d want 100", phase); else n_pass++;
    tick;
  endtask

  task automatic test_backpressure;
    do_reset;
    cfg(7'd7, 7'd2);
    out_ready = 1'b0;
    sample_req = 1'b1; tick; sample_req = 1'b0;
    tick; tick;
    n_total++; if (out_valid !== 1'b1 || out_code !== 7'd9)
      $display("FAIL bp_result: got valid=%0b code=%0d want 1/9", out_valid, out_code); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL bp_no_overrun: got %0b want 0", overrun); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      sample_req = (c % 2 == 0);
      tick;
      n_total++; if (out_valid !== 1'b1 || out_code !== 7'd9 || busy !== 1'b1)
        $display("FAIL bp_hold: got valid=%0b code=%0d busy=%0b want 1/9/1", out_valid, out_code, busy);
      else n_pass++;
    end
    sample_req = 1'b0;
    n_total++; if (overrun !== 1'b1) $display("FAIL bp_overrun_set: got %0b want 1", overrun); else n_pass++;
    out_ready = 1'b1; tick;
    n_total++; if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1)
      $display("FAIL bp_release: got valid=%0b busy=%0b ovr=%0b want 0/0/1", out_valid, busy, overrun); else n_pass++;
    cfg(7'd7, 7'd2);
    n_total++; if (overrun !== 1'b0) $display("FAIL bp_cfg_clear: got %0b want 0", overrun); else n_pass++;
    // cfg_load beats a simultaneous overrun event (request while disabled)
    enable = 1'b0; sample_req = 1'b1; cfg_load = 1'b1;
    tick;
    cfg_load = 1'b0; sample_req = 1'b0; enable = 1'b1;
    n_total++; if (overrun !== 1'b0) $display("FAIL bp_cfg_wins: got %0b want 0", overrun); else n_pass++;
    sample_req = 1'b1; enable = 1'b0; tick; sample_req = 1'b0; enable = 1'b1;
    n_total++; if (overrun !== 1'b1 || busy !== 1'b0)
      $display("FAIL bp_idle_disabled: got ovr=%0b busy=%0b want 1/0", overrun, busy); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [6:0] exp;
    do_reset;
    cfg(7'd1, 7'd0);
    out_ready = 1'b1;
    sample_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick;
      n_total++; if (out_valid !== (c % 3 == 0) || busy !== 1'b1)
        $display("FAIL b2b_timing c=%0d: got valid=%0b busy=%0b want %0b/1", c, out_valid, busy, (c % 3 == 0));
      else n_pass++;
      if (c % 3 == 0) begin
        m_phase = next_phase(m_phase, m_step);
        exp = exp_code(m_phase, m_off);
        n_total++; if (out_code !== exp) $display("FAIL b2b_code: got %0d want %0d", out_code, exp); else n_pass++;
      end
    end
    sample_req = 1'b0;
    tick;
    n_total++; if (busy !== 1'b0 || phase !== 7'd3)
      $display("FAIL b2b_end: got busy=%0b phase=%0d want 0/3", busy, phase); else n_pass++;
  endtask

  task automatic test_abort;
    do_reset;
    cfg(7'd9, 7'd4);
    sample_req = 1'b1; tick; sample_req = 1'b0;
    tick;
    enable = 1'b0; tick;
    n_total++; if (busy !== 1'b0 || out_valid !== 1'b0 || phase !== 7'd9 || out_code !== 7'd0)
      $display("FAIL abort_offset: got busy=%0b valid=%0b phase=%0d code=%0d want 0/0/9/0",
               busy, out_valid, phase, out_code); else n_pass++;
    enable = 1'b1; tick;
    n_total++; if (out_valid !== 1'b0) $display("FAIL abort_quiet: got %0b want 0", out_valid); else n_pass++;
    sample_req = 1'b1; tick; sample_req = 1'b0;
    enable = 1'b0; tick; enable = 1'b1;
    n_total++; if (phase !== 7'd9 || busy !== 1'b0)
      $display("FAIL abort_phase: got phase=%0d busy=%0b want 9/0", phase, busy); else n_pass++;
    sample_req = 1'b1; tick; sample_req = 1'b0;
    rst_n = 1'b0; tick; rst_n = 1'b1;
    n_total++; if (phase !== 7'd0 || busy !== 1'b0 || out_valid !== 1'b0 || overrun !== 1'b0 ||
                   add_a !== 7'd0 || add_b !== 7'd0 || out_code !== 7'd0)
      $display("FAIL abort_reset: got phase=%0d busy=%0b valid=%0b ovr=%0b a=%0d b=%0d code=%0d want all 0",
               phase, busy, out_valid, overrun, add_a, add_b, out_code); else n_pass++;
  endtask

  task automatic test_random;
    bit to;
    logic [6:0] exp, s, o;
    int d;
    do_reset;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(1, 0) == 1) cfg(7'($urandom), 7'($urandom));
      for (int g = 0; g < int'($urandom_range(2, 0)); g++) tick;
      out_ready = 1'b0;
      sample_req = 1'b1; tick; sample_req = 1'b0;
      m_phase = next_phase(m_phase, m_step);
      exp = exp_code(m_phase, m_off);
      if ($urandom_range(1, 0) == 1) begin
        s = 7'($urandom); o = 7'($urandom);
        cfg(s, o);
      end else begin
        tick;
      end
      to = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (out_valid) begin to = 1'b0; break; end
        tick;
      end
      n_total++; if (to) $display("FAIL rnd_timeout it=%0d: got no out_valid want out_valid", it);
      else if (out_code !== exp || phase !== m_phase)
        $display("FAIL rnd_sample it=%0d: got code=%0d phase=%0d want %0d/%0d", it, out_code, phase, exp, m_phase);
      else n_pass++;
      d = int'($urandom_range(3, 0));
      for (int h = 0; h < d; h++) tick;
      n_total++; if (out_valid !== 1'b1 || out_code !== exp)
        $display("FAIL rnd_hold it=%0d: got valid=%0b code=%0d want 1/%0d", it, out_valid, out_code, exp);
      else n_pass++;
      out_ready = 1'b1; tick;
      n_total++; if (out_valid !== 1'b0) $display("FAIL rnd_release it=%0d: got %0b want 0", it, out_valid);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_wrap;
    test_fold;
    test_backpressure;
    test_back_to_back;
    test_abort;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit reached want completion, %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
